// File: rtl/crypto_trigger_gen_if.sv
// Control/status bundle between the crypto register block and the trigger sequencer.
// The register block drives the master side; crypto_trigger_gen uses the slave side.
interface crypto_trigger_gen_if #(
  parameter int unsigned pDLY_WIDTH = 16,
  parameter int unsigned pWID_WIDTH = 16,
  parameter int unsigned pRPT_WIDTH = 8
);
  logic [1:0]            I_mode;
  logic [pDLY_WIDTH-1:0] I_delay;
  logic [pWID_WIDTH-1:0] I_width;
  logic [pRPT_WIDTH-1:0] I_repeat;
  logic                  I_arm;
  logic                  I_disarm;
  logic                  I_start;
  logic                  I_busy;
  logic                  O_trigger;
  logic                  O_armed;
  logic                  O_done;
  logic [pRPT_WIDTH-1:0] O_remaining;
  logic [7:0]            O_missed;

  modport master (
    output I_mode, I_delay, I_width, I_repeat, I_arm, I_disarm, I_start, I_busy,
    input  O_trigger, O_armed, O_done, O_remaining, O_missed
  );

  modport slave (
    input  I_mode, I_delay, I_width, I_repeat, I_arm, I_disarm, I_start, I_busy,
    output O_trigger, O_armed, O_done, O_remaining, O_missed
  );
endinterface

// File: rtl/crypto_trigger_gen.sv
// Programmable side-channel trigger sequencer: FOLLOW / PULSE / WINDOW modes with a
// cycle-exact delay, pulse width and a multi-encryption batch counter.
module crypto_trigger_gen #(
  parameter int unsigned pDLY_WIDTH = 16,
  parameter int unsigned pWID_WIDTH = 16,
  parameter int unsigned pRPT_WIDTH = 8
) (
  input  logic                crypto_clk,
  input  logic                resetn,
  crypto_trigger_gen_if.slave trig_bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StDelay, StActive} state_e;

  localparam logic [1:0] ModeFollow = 2'd0;
  localparam logic [1:0] ModePulse  = 2'd1;
  localparam logic [1:0] ModeWindow = 2'd2;

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [pDLY_WIDTH-1:0] delay_q;
  logic [pDLY_WIDTH-1:0] dcnt_q;
  logic [pWID_WIDTH-1:0] width_q;
  logic [pWID_WIDTH-1:0] wcnt_q;
  logic [pRPT_WIDTH-1:0] repeat_q;
  logic [pRPT_WIDTH-1:0] rem_q;
  logic [7:0]            missed_q;
  logic                  trig_q;
  logic                  armed_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  timed_mode;
  logic [pWID_WIDTH-1:0] width_eff;
  logic                  pulse_end;
  logic                  window_end;
  logic                  follow_fall;
  logic                  event_end;
  logic                  start_missed;
  logic                  batch_last;

  always_comb begin
    timed_mode   = (mode_q == ModePulse) || (mode_q == ModeWindow);
    width_eff    = (width_q == '0) ? pWID_WIDTH'(1) : width_q;
    // ACTIVE spends its first cycle raising the trigger; ends are only checked once it is high.
    pulse_end    = (state_q == StActive) && trig_q && (mode_q == ModePulse) &&
                   (wcnt_q == pWID_WIDTH'(1));
    window_end   = (state_q == StActive) && trig_q && (mode_q == ModeWindow) &&
                   !trig_bus.I_busy;
    follow_fall  = (state_q == StArmed) && (mode_q == ModeFollow) && busy_q &&
                   !trig_bus.I_busy;
    event_end    = pulse_end || window_end || follow_fall;
    start_missed = trig_bus.I_start && ((state_q == StDelay) || (state_q == StActive));
    batch_last   = (repeat_q != '0) && (rem_q == pRPT_WIDTH'(1));
  end

  always_ff @(posedge crypto_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      mode_q   <= 2'd0;
      delay_q  <= '0;
      dcnt_q   <= '0;
      width_q  <= '0;
      wcnt_q   <= '0;
      repeat_q <= '0;
      rem_q    <= '0;
      missed_q <= 8'd0;
      trig_q   <= 1'b0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= trig_bus.I_busy;
      if (start_missed && (missed_q != 8'hff)) begin
        missed_q <= missed_q + 8'd1;
      end

      if (trig_bus.I_disarm) begin
        state_q <= StIdle;
        trig_q  <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (trig_bus.I_arm) begin
              mode_q   <= trig_bus.I_mode;
              delay_q  <= trig_bus.I_delay;
              width_q  <= trig_bus.I_width;
              repeat_q <= trig_bus.I_repeat;
              rem_q    <= trig_bus.I_repeat;
              missed_q <= 8'd0;
              armed_q  <= 1'b1;
              state_q  <= StArmed;
            end
          end
          StArmed: begin
            if (mode_q == ModeFollow) begin
              trig_q <= trig_bus.I_busy;
            end
            if (timed_mode && trig_bus.I_start) begin
              wcnt_q <= width_eff;
              if (delay_q == '0) begin
                state_q <= StActive;
              end else begin
                dcnt_q  <= delay_q;
                state_q <= StDelay;
              end
            end
          end
          StDelay: begin
            if (dcnt_q == pDLY_WIDTH'(1)) begin
              state_q <= StActive;
            end else begin
              dcnt_q <= dcnt_q - pDLY_WIDTH'(1);
            end
          end
          StActive: begin
            if (!trig_q) begin
              trig_q <= 1'b1;
            end else if ((mode_q == ModePulse) && (wcnt_q != pWID_WIDTH'(1))) begin
              wcnt_q <= wcnt_q - pWID_WIDTH'(1);
            end
          end
          default: state_q <= StIdle;
        endcase

        // Shared end-of-event bookkeeping overrides the per-state updates above.
        if (event_end) begin
          trig_q <= 1'b0;
          if (repeat_q == '0) begin
            state_q <= StArmed;
          end else begin
            rem_q <= rem_q - pRPT_WIDTH'(1);
            if (batch_last) begin
              state_q <= StIdle;
              armed_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StArmed;
            end
          end
        end
      end
    end
  end

  assign trig_bus.O_trigger   = trig_q;
  assign trig_bus.O_armed     = armed_q;
  assign trig_bus.O_done      = done_q;
  assign trig_bus.O_remaining = rem_q;
  assign trig_bus.O_missed    = missed_q;

endmodule

// File: tb/tb_crypto_trigger_gen.sv
// Directed bench for crypto_trigger_gen: per-edge expected trigger/done values are queued
// when stimulus is driven and compared as the DUT produces them.
module tb_crypto_trigger_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 16;
  localparam int unsigned RW = 8;

  typedef struct packed {
    logic trig;
    logic done;
  } exp_t;

  logic crypto_clk = 1'b0;
  logic resetn     = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   edge_no    = 0;
  exp_t exp_q[$];

  crypto_trigger_gen_if #(.pDLY_WIDTH(DW), .pWID_WIDTH(WW), .pRPT_WIDTH(RW)) bus ();

  crypto_trigger_gen #(.pDLY_WIDTH(DW), .pWID_WIDTH(WW), .pRPT_WIDTH(RW)) dut (
    .crypto_clk (crypto_clk),
    .resetn     (resetn),
    .trig_bus   (bus.slave)
  );

  always #5 crypto_clk = ~crypto_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic t, input logic d, input int n);
    exp_t e;
    e.trig = t;
    e.done = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One rising edge; outputs sampled on the following falling edge.
  task automatic tick();
    exp_t e;
    @(posedge crypto_clk);
    edge_no++;
    @(negedge crypto_clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("trigger@edge%0d", edge_no), 32'(bus.O_trigger), 32'(e.trig));
      chk($sformatf("done@edge%0d", edge_no), 32'(bus.O_done), 32'(e.done));
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) begin
      chk("drain timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic arm(input logic [1:0] m, input int d, input int w, input int r);
    bus.I_mode   = m;
    bus.I_delay  = DW'(d);
    bus.I_width  = WW'(w);
    bus.I_repeat = RW'(r);
    bus.I_arm    = 1'b1;
    tick();
    bus.I_arm    = 1'b0;
  endtask

  task automatic disarm();
    bus.I_disarm = 1'b1;
    tick();
    bus.I_disarm = 1'b0;
  endtask

  initial begin
    bus.I_mode   = 2'd0;
    bus.I_delay  = '0;
    bus.I_width  = '0;
    bus.I_repeat = '0;
    bus.I_arm    = 1'b0;
    bus.I_disarm = 1'b0;
    bus.I_start  = 1'b0;
    bus.I_busy   = 1'b0;
    repeat (3) @(negedge crypto_clk);
    chk("reset trigger",   32'(bus.O_trigger),   32'd0);
    chk("reset armed",     32'(bus.O_armed),     32'd0);
    chk("reset done",      32'(bus.O_done),      32'd0);
    chk("reset remaining", 32'(bus.O_remaining), 32'd0);
    chk("reset missed",    32'(bus.O_missed),    32'd0);
    resetn = 1'b1;
    tick();

    // Disarm beats a simultaneous arm.
    bus.I_disarm = 1'b1;
    arm(2'd1, 0, 1, 1);
    bus.I_disarm = 1'b0;
    chk("arm+disarm armed", 32'(bus.O_armed), 32'd0);

    // PULSE delay=3 width=2 repeat=1.
    arm(2'd1, 3, 2, 1);
    chk("pulse armed", 32'(bus.O_armed), 32'd1);
    chk("pulse remaining init", 32'(bus.O_remaining), 32'd1);
    repeat (2) tick();
    bus.I_start = 1'b1;
    push(1'b0, 1'b0, 4);
    push(1'b1, 1'b0, 2);
    push(1'b0, 1'b1, 1);
    push(1'b0, 1'b0, 1);
    tick();
    bus.I_start = 1'b0;
    drain(40);
    chk("pulse armed after", 32'(bus.O_armed), 32'd0);
    chk("pulse remaining after", 32'(bus.O_remaining), 32'd0);

    // WINDOW delay=0 repeat=2, busy high for 12 cycles after each start.
    arm(2'd2, 0, 0, 2);
    chk("window remaining init", 32'(bus.O_remaining), 32'd2);
    for (int k = 0; k < 2; k++) begin
      bus.I_start = 1'b1;
      push(1'b0, 1'b0, 1);
      push(1'b1, 1'b0, 12);
      push(1'b0, (k == 1), 1);
      push(1'b0, 1'b0, 1);
      tick();
      bus.I_start = 1'b0;
      bus.I_busy  = 1'b1;
      repeat (12) tick();
      bus.I_busy  = 1'b0;
      drain(10);
      chk($sformatf("window remaining %0d", k), 32'(bus.O_remaining), 32'(1 - k));
      tick();
    end
    chk("window armed after", 32'(bus.O_armed), 32'd0);

    // FOLLOW repeat=0: trigger is busy delayed one cycle; arm while armed is ignored.
    arm(2'd0, 0, 0, 0);
    begin
      logic [15:0] pat;
      pat = 16'b0011_1011_0011_1000;
      for (int i = 15; i >= 0; i--) begin
        bus.I_busy = pat[i];
        bus.I_arm  = (i == 8);
        bus.I_repeat = RW'(5);
        push(pat[i], 1'b0, 1);
        tick();
      end
      bus.I_arm = 1'b0;
    end
    chk("follow armed", 32'(bus.O_armed), 32'd1);
    chk("follow remaining", 32'(bus.O_remaining), 32'd0);
    bus.I_busy = 1'b1;
    disarm();
    bus.I_busy = 1'b0;
    chk("follow disarm trigger", 32'(bus.O_trigger), 32'd0);
    chk("follow disarm armed", 32'(bus.O_armed), 32'd0);
    chk("follow disarm done", 32'(bus.O_done), 32'd0);

    // PULSE delay=100, starts 10 cycles apart: only the first is taken.
    arm(2'd1, 100, 1, 0);
    push(1'b0, 1'b0, 101);
    push(1'b1, 1'b0, 1);
    push(1'b0, 1'b0, 1);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      bus.I_start = (i == 0) || (i == 10) || (i == 20);
      tick();
    end
    bus.I_start = 1'b0;
    drain(5);
    chk("missed count", 32'(bus.O_missed), 32'd2);
    chk("unlimited armed", 32'(bus.O_armed), 32'd1);
    disarm();

    // delay=0 width=0 gives a single-cycle pulse one edge after start.
    arm(2'd1, 0, 0, 1);
    chk("missed cleared", 32'(bus.O_missed), 32'd0);
    bus.I_start = 1'b1;
    push(1'b0, 1'b0, 1);
    push(1'b1, 1'b0, 1);
    push(1'b0, 1'b1, 1);
    push(1'b0, 1'b0, 1);
    tick();
    bus.I_start = 1'b0;
    drain(10);

    // Mode 3 never triggers and never counts starts.
    arm(2'd3, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      bus.I_start = (i % 5 == 0) && (i < 20);
      bus.I_busy  = i[1];
      push(1'b0, 1'b0, 1);
      tick();
    end
    bus.I_start = 1'b0;
    bus.I_busy  = 1'b0;
    chk("mode3 missed", 32'(bus.O_missed), 32'd0);
    chk("mode3 armed", 32'(bus.O_armed), 32'd1);
    chk("mode3 remaining", 32'(bus.O_remaining), 32'd1);
    disarm();

    // Asynchronous reset in the middle of a long pulse.
    arm(2'd1, 0, 10, 1);
    bus.I_start = 1'b1;
    push(1'b0, 1'b0, 1);
    push(1'b1, 1'b0, 3);
    tick();
    bus.I_start = 1'b0;
    tick();
    bus.I_start = 1'b1;
    tick();
    bus.I_start = 1'b0;
    drain(5);
    chk("pre-reset missed", 32'(bus.O_missed), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async reset trigger",   32'(bus.O_trigger),   32'd0);
    chk("async reset armed",     32'(bus.O_armed),     32'd0);
    chk("async reset done",      32'(bus.O_done),      32'd0);
    chk("async reset remaining", 32'(bus.O_remaining), 32'd0);
    chk("async reset missed",    32'(bus.O_missed),    32'd0);
    @(negedge crypto_clk);
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
